// File: rtl/mic_pkg.sv
// Shared constants and types for the MIC register file and its memory sequencer.
package mic_pkg;

   // B-bus select codes
   localparam int unsigned BSelOpc  = 0;
   localparam int unsigned BSelTos  = 1;
   localparam int unsigned BSelCpp  = 2;
   localparam int unsigned BSelLv   = 3;
   localparam int unsigned BSelSp   = 4;
   localparam int unsigned BSelMbr  = 5;
   localparam int unsigned BSelPc   = 6;
   localparam int unsigned BSelMdr  = 7;
   localparam int unsigned BSelMbru = 8;

   // write_c bit indices
   localparam int unsigned WcMar = 0;
   localparam int unsigned WcMdr = 1;
   localparam int unsigned WcPc  = 2;
   localparam int unsigned WcSp  = 3;
   localparam int unsigned WcLv  = 4;
   localparam int unsigned WcCpp = 5;
   localparam int unsigned WcTos = 6;
   localparam int unsigned WcOpc = 7;
   localparam int unsigned WcH   = 8;

   // mem_control bit indices
   localparam int unsigned McFetch = 0;
   localparam int unsigned McRd    = 1;
   localparam int unsigned McWr    = 2;

   typedef enum logic [1:0] {
      StIdle,
      StRd,
      StWr
   } seq_state_e;

endpackage

// File: rtl/mic_mem_sequencer.sv
// Moves one NBITS-wide word over the byte-wide memory port, one byte per cycle,
// little-endian, starting at byte address MAR * BYTES.
module mic_mem_sequencer
   import mic_pkg::*;
#(
   parameter int unsigned NBITS = 32,
   parameter int unsigned WORD  = 8,
   parameter int unsigned KW    = $clog2(NBITS / WORD)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_req,
   input  logic             wr_req,
   input  logic [NBITS-1:0] mar,
   output logic             busy,
   output logic             we,
   output logic [NBITS-1:0] addr,
   output logic [KW-1:0]    byte_idx,
   output logic             byte_load
);

   localparam int unsigned BYTES = NBITS / WORD;

   seq_state_e       state_q;
   logic [KW-1:0]    k_q;
   logic [NBITS-1:0] base_q;

   // busy and we are registered alongside the state so they are glitch-free
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         k_q     <= '0;
         base_q  <= '0;
         busy    <= 1'b0;
         we      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (rd_req ^ wr_req) begin
                  base_q  <= mar;
                  k_q     <= '0;
                  busy    <= 1'b1;
                  we      <= wr_req;
                  state_q <= rd_req ? StRd : StWr;
               end
            end
            StRd, StWr: begin
               if (k_q == KW'(BYTES - 1)) begin
                  state_q <= StIdle;
                  k_q     <= '0;
                  busy    <= 1'b0;
                  we      <= 1'b0;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               k_q     <= '0;
               busy    <= 1'b0;
               we      <= 1'b0;
            end
         endcase
      end
   end

   assign addr      = (base_q << KW) + NBITS'(k_q);
   assign byte_idx  = k_q;
   assign byte_load = (state_q == StRd);

endmodule

// File: rtl/mic_regfile_mem.sv
// MIC datapath register file with a multi-cycle word sequencer on a byte-wide memory port.
// Define MIC_MBRU_EN to make B code 8 select the zero-extended MBR.
module mic_regfile_mem
   import mic_pkg::*;
#(
   parameter int unsigned NBITS = 32,
   parameter int unsigned WORD  = 8,
   parameter int unsigned B     = 4,
   parameter int unsigned C     = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NBITS-1:0] c_bus,
   input  logic [C-1:0]     write_c,
   input  logic [B-1:0]     enable_b,
   output logic [NBITS-1:0] b_bus,
   output logic [NBITS-1:0] h_out,
   input  logic [2:0]       mem_control,
   input  logic [WORD-1:0]  mem_in,
   output logic [NBITS-1:0] mem_addr,
   output logic [WORD-1:0]  mem_out,
   output logic             we,
   output logic             busy
);

   localparam int unsigned KW = $clog2(NBITS / WORD);

   logic [NBITS-1:0] mar_q, mdr_q, pc_q, sp_q, lv_q, cpp_q, tos_q, opc_q, h_q;
   logic [WORD-1:0]  mbr_q;

   logic [NBITS-1:0] seq_addr;
   logic [KW-1:0]    byte_idx;
   logic             byte_load;

   mic_mem_sequencer #(
      .NBITS(NBITS),
      .WORD (WORD),
      .KW   (KW)
   ) u_seq (
      .clk      (clk),
      .reset    (reset),
      .rd_req   (mem_control[McRd]),
      .wr_req   (mem_control[McWr]),
      .mar      (mar_q),
      .busy     (busy),
      .we       (we),
      .addr     (seq_addr),
      .byte_idx (byte_idx),
      .byte_load(byte_load)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         mar_q <= '0;
         mdr_q <= '0;
         pc_q  <= '0;
         sp_q  <= '0;
         lv_q  <= '0;
         cpp_q <= '0;
         tos_q <= '0;
         opc_q <= '0;
         h_q   <= '0;
         mbr_q <= '0;
      end else begin
         if (write_c[WcMar]) mar_q <= c_bus;
         if (write_c[WcPc])  pc_q  <= c_bus;
         if (write_c[WcSp])  sp_q  <= c_bus;
         if (write_c[WcLv])  lv_q  <= c_bus;
         if (write_c[WcCpp]) cpp_q <= c_bus;
         if (write_c[WcTos]) tos_q <= c_bus;
         if (write_c[WcOpc]) opc_q <= c_bus;
         if (write_c[WcH])   h_q   <= c_bus;
         // MDR belongs to the sequencer for the whole transfer; C writes are dropped
         if (byte_load) begin
            mdr_q[byte_idx*WORD +: WORD] <= mem_in;
         end else if (!busy && write_c[WcMdr]) begin
            mdr_q <= c_bus;
         end
         if (!busy && mem_control[McFetch]) mbr_q <= mem_in;
      end
   end

   always_comb begin
      int unsigned sel;
      sel   = 32'(enable_b);
      b_bus = opc_q;
      case (sel)
         BSelOpc:  b_bus = opc_q;
         BSelTos:  b_bus = tos_q;
         BSelCpp:  b_bus = cpp_q;
         BSelLv:   b_bus = lv_q;
         BSelSp:   b_bus = sp_q;
         BSelMbr:  b_bus = {{(NBITS - WORD){mbr_q[WORD-1]}}, mbr_q};
         BSelPc:   b_bus = pc_q;
         BSelMdr:  b_bus = mdr_q;
`ifdef MIC_MBRU_EN
         BSelMbru: b_bus = {{(NBITS - WORD){1'b0}}, mbr_q};
`endif
         default:  b_bus = opc_q;
      endcase
   end

   assign h_out    = h_q;
   assign mem_addr = busy ? seq_addr : pc_q;
   // byte_idx rests at 0 when idle, so this also gives MDR byte 0 in IDLE
   assign mem_out  = mdr_q[byte_idx*WORD +: WORD];

endmodule

// File: tb/tb_mic_regfile_mem.sv
// Self-checking bench for mic_regfile_mem against a word/byte-level reference model.
module tb_mic_regfile_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] c_bus;
   logic [8:0]  write_c;
   logic [3:0]  enable_b;
   logic [31:0] b_bus, h_out, mem_addr;
   logic [2:0]  mem_control;
   logic [7:0]  mem_in, mem_out;
   logic        we, busy;

   logic [7:0]  mem [256];
   // Model registers indexed by write_c bit: MAR MDR PC SP LV CPP TOS OPC H
   logic [31:0] m_reg [9];
   logic [7:0]  m_mbr;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   always #50 clk = ~clk;

   assign mem_in = mem[mem_addr[7:0]];

   mic_regfile_mem dut (
      .clk        (clk),
      .reset      (reset),
      .c_bus      (c_bus),
      .write_c    (write_c),
      .enable_b   (enable_b),
      .b_bus      (b_bus),
      .h_out      (h_out),
      .mem_control(mem_control),
      .mem_in     (mem_in),
      .mem_addr   (mem_addr),
      .mem_out    (mem_out),
      .we         (we),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_b(input int code);
      case (code)
         0: return m_reg[7];
         1: return m_reg[6];
         2: return m_reg[5];
         3: return m_reg[4];
         4: return m_reg[3];
         5: return {{24{m_mbr[7]}}, m_mbr};
         6: return m_reg[2];
         7: return m_reg[1];
`ifdef MIC_MBRU_EN
         8: return {24'h0, m_mbr};
`endif
         default: return m_reg[7];
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 16; i++) begin
         enable_b = 4'(i);
         #1;
         chk($sformatf("%s b_bus[%0d]", tag, i), b_bus, exp_b(i));
      end
      chk({tag, " h_out"}, h_out, m_reg[8]);
   endtask

   task automatic cwrite(input logic [8:0] mask, input logic [31:0] v);
      write_c = mask;
      c_bus   = v;
      cyc();
      write_c = '0;
      for (int i = 0; i < 9; i++) if (mask[i]) m_reg[i] = v;
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
      logic [7:0] a;
      a = byte_addr[7:0];
      return {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[a]};
   endfunction

   // Read MAR=a; a stray fetch during the transfer must be ignored
   task automatic do_read(input logic [31:0] a, input string tag);
      cwrite(9'h001, a);
      mem_control = 3'b010;
      cyc();
      mem_control = 3'b000;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) mem_control = 3'b001;
         #1;
         chk($sformatf("%s busy k%0d", tag, k), 32'(busy), 32'd1);
         chk($sformatf("%s addr k%0d", tag, k), mem_addr, a * 4 + k);
         chk($sformatf("%s we k%0d", tag, k), 32'(we), 32'd0);
         cyc();
         mem_control = 3'b000;
      end
      m_reg[1] = word_at(a * 4);
      #1;
      chk({tag, " busy end"}, 32'(busy), 32'd0);
      check_all(tag);
   endtask

   // Write d to MAR=a; a C write of MDR+MAR mid-transfer updates MAR only
   task automatic do_write(input logic [31:0] d, input logic [31:0] a, input string tag);
      logic [31:0] junk;
      cwrite(9'h002, d);
      cwrite(9'h001, a);
      #1;
      chk({tag, " idle mem_out"}, 32'(mem_out), 32'(d[7:0]));
      mem_control = 3'b100;
      cyc();
      mem_control = 3'b000;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin
            junk     = $urandom;
            write_c  = 9'h003;
            c_bus    = junk;
            m_reg[0] = junk;
         end
         #1;
         chk($sformatf("%s busy k%0d", tag, k), 32'(busy), 32'd1);
         chk($sformatf("%s we k%0d", tag, k), 32'(we), 32'd1);
         chk($sformatf("%s addr k%0d", tag, k), mem_addr, a * 4 + k);
         chk($sformatf("%s data k%0d", tag, k), 32'(mem_out), 32'((d >> (8 * k)) & 32'hFF));
         cyc();
         write_c = '0;
      end
      #1;
      chk({tag, " we end"}, 32'(we), 32'd0);
      chk({tag, " busy end"}, 32'(busy), 32'd0);
      check_all(tag);
   endtask

   initial begin
      reset       = 1'b1;
      c_bus       = '0;
      write_c     = '0;
      enable_b    = '0;
      mem_control = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 9; i++) m_reg[i] = '0;
      m_mbr = '0;

      cyc();
      cyc();
      reset = 1'b0;
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset we", 32'(we), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      check_all("reset");

      // Random C writes, several registers at once
      for (int i = 0; i < 6; i++) begin
         cwrite(9'($urandom_range(1, 511)), $urandom);
         #1;
         chk($sformatf("cw%0d mem_addr", i), mem_addr, m_reg[2]);
         check_all($sformatf("cw%0d", i));
      end

      // Directed read of word at byte 0x40
      mem[8'h40] = 8'h11;
      mem[8'h41] = 8'h22;
      mem[8'h42] = 8'h33;
      mem[8'h43] = 8'h44;
      do_read(32'h10, "rd_dir");
      chk("rd_dir mdr", exp_b(7), 32'h44332211);

      for (int i = 0; i < 3; i++) do_read(32'($urandom_range(0, 60)), $sformatf("rd_rnd%0d", i));

      do_write(32'hDEADBEEF, 32'h1, "wr_dir");
      for (int i = 0; i < 2; i++) do_write($urandom, $urandom, $sformatf("wr_rnd%0d", i));

      // Fetch with a negative byte
      mem[5] = 8'h80;
      cwrite(9'h004, 32'h5);
      mem_control = 3'b001;
      #1;
      chk("fetch addr", mem_addr, 32'h5);
      cyc();
      mem_control = 3'b000;
      m_mbr = 8'h80;
      check_all("fetch");

      // Fetch together with rd: mbr loads now, transfer starts next cycle
      cwrite(9'h004, 32'h7);
      cwrite(9'h001, 32'h8);
      mem_control = 3'b011;
      cyc();
      mem_control = 3'b000;
      m_mbr = mem[7];
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("frd busy k%0d", k), 32'(busy), 32'd1);
         chk($sformatf("frd addr k%0d", k), mem_addr, 32'h20 + k);
         cyc();
      end
      m_reg[1] = word_at(32'h20);
      check_all("frd");

      // rd and wr together: no operation
      mem_control = 3'b110;
      cyc();
      mem_control = 3'b000;
      #1;
      chk("rdwr busy", 32'(busy), 32'd0);
      chk("rdwr we", 32'(we), 32'd0);
      chk("rdwr addr", mem_addr, m_reg[2]);
      check_all("rdwr");

      // Reset during the second RD cycle
      cwrite(9'h001, 32'h20);
      mem_control = 3'b010;
      cyc();
      mem_control = 3'b000;
      #1;
      chk("rst_mid busy k0", 32'(busy), 32'd1);
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 9; i++) m_reg[i] = '0;
      m_mbr = '0;
      #1;
      chk("rst_mid busy", 32'(busy), 32'd0);
      chk("rst_mid we", 32'(we), 32'd0);
      chk("rst_mid addr", mem_addr, 32'd0);
      check_all("rst_mid");
      do_read(32'h30, "rd_after_rst");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
